controlador_ventana_5x8: RTL
============================

Name: controlador_ventana_5x8

Overview:
Sequencer that fills the 5x8 window buffer from image memory and hands each completed window to the filter stage. Walks the image in 8-pixel column blocks and row positions, fetching 5 vertically stacked 64-bit words per window position. Drives the window's `guardar`/`datos_entrada` and waits for the filter's acknowledge before advancing. Sits between the image memory read port and the window buffer + filter core.

Parameters:
ANCHO_BLOQUES, 80, image width in 64-bit words (8 pixels each).
ALTO_FILAS, 480, image height in pixel rows. Must be >= 5.
BITS_DIRECCION, 16, memory address width. ANCHO_BLOQUES*ALTO_FILAS must be <= 2^BITS_DIRECCION.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
iniciar  in  1  start pulse; sampled only in REPOSO.
mem_leer  out  1  one-cycle read request.
mem_direccion  out  BITS_DIRECCION  read address, valid while mem_leer=1; held until next request.
mem_valido  in  1  read data valid, one cycle; at least 1 cycle after mem_leer.
mem_datos  in  64  read data.
guardar  out  1  one-cycle write strobe to the window buffer.
datos_ventana  out  64  data to the window buffer, valid while guardar=1.
ventana_lista  out  1  all 5 rows loaded; held until acknowledged.
filtro_listo  in  1  filter acknowledge; consumed only while ventana_lista=1.
columna  out  BITS_DIRECCION  current column block, 0..ANCHO_BLOQUES-1.
fila  out  BITS_DIRECCION  current base row, 0..ALTO_FILAS-5.
ocupado  out  1  high in any state other than REPOSO.
terminado  out  1  one-cycle pulse after the last window is acknowledged.

Behaviour:
- Reset values: all outputs 0. State REPOSO. Internal row counter k=0. The window buffer shares `reset`, so its row pointer realigns to row 1.
- States:
  - REPOSO: if iniciar, then columna=0, fila=0, k=0, and go to LEER.
  - LEER: mem_leer=1 for exactly one cycle, with mem_direccion=(fila+k)*ANCHO_BLOQUES+columna. Go to ESPERAR.
  - ESPERAR: wait for mem_valido. On mem_valido, register mem_datos and go to CARGAR.
  - CARGAR: guardar=1 for one cycle, with datos_ventana=registered word.
    - If k=4, then k=0 and go to LISTA.
    - Otherwise k=k+1 and go to LEER.
  - LISTA: ventana_lista=1. On filtro_listo, go to AVANZAR. ventana_lista drops the cycle after filtro_listo is seen.
  - AVANZAR (1 cycle):
    - If columna<ANCHO_BLOQUES-1, then columna+1.
    - Otherwise, if fila<ALTO_FILAS-5, then columna=0 and fila+1.
    - Otherwise go to FIN.
    - In the non-final cases go to LEER.
  - FIN: terminado=1 for one cycle, then REPOSO.
- Addressing: the address is computed with an adder stepping by ANCHO_BLOQUES per k (no multiplier required); results are mod 2^BITS_DIRECCION.
- Exactly 5 guardar pulses per window, so the window buffer's one-hot pointer stays aligned: fila_1..fila_5 = rows fila..fila+4.
- Latency with 1-cycle memory: 3 cycles per row, 15 cycles from the first mem_leer to ventana_lista.
- Total windows = ANCHO_BLOQUES*(ALTO_FILAS-4).
- Boundary rules:
  - iniciar while ocupado is ignored.
  - mem_valido outside ESPERAR is ignored.
  - filtro_listo outside LISTA is ignored.
  - filtro_listo already high on LISTA entry is accepted on the first LISTA cycle.
  - Reset mid-operation aborts immediately: no further mem_leer or guardar, all outputs 0.
  - ALTO_FILAS=5 gives a single row position.

Test Plan:
1. ANCHO_BLOQUES=4, ALTO_FILAS=6, 1-cycle memory returning data=address; pulse iniciar -> mem_direccion sequence 0,4,8,12,16; guardar pulses carry those values; ventana_lista asserts 15 cycles after the first mem_leer.
2. Same config, acknowledge each window after 2 cycles -> second window addresses 1,5,9,13,17; fifth window (fila=1, columna=0) addresses 4,8,12,16,20; last window 7,11,15,19,23. Then terminado pulses once, after 8 windows total.
3. Memory latency randomized 1..6 cycles, with spurious mem_valido during LEER/CARGAR/LISTA -> exactly 5 guardar pulses per window, data matching the requested addresses.
4. Pulse iniciar and filtro_listo at random while ocupado -> no restart; no advance outside LISTA.
5. Assert reset during ESPERAR of the third row -> all outputs 0 next cycle, state REPOSO. A new iniciar restarts at address 0; the window buffer shows fila_1=word@0 after the first guardar.
6. ALTO_FILAS=5, ANCHO_BLOQUES=1 -> single window at addresses 0,1,2,3,4; terminado follows the first acknowledge.

Source files
------------

// File: rtl/controlador_ventana_5x8.sv
// controlador_ventana_5x8: walks the image in 8-pixel column blocks, loads 5 stacked words per window, hands each window to the filter
module controlador_ventana_5x8 #(
    parameter int ANCHO_BLOQUES  = 80,
    parameter int ALTO_FILAS     = 480,
    parameter int BITS_DIRECCION = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iniciar,
    output logic                      mem_leer,
    output logic [BITS_DIRECCION-1:0] mem_direccion,
    input  logic                      mem_valido,
    input  logic [63:0]               mem_datos,
    output logic                      guardar,
    output logic [63:0]               datos_ventana,
    output logic                      ventana_lista,
    input  logic                      filtro_listo,
    output logic [BITS_DIRECCION-1:0] columna,
    output logic [BITS_DIRECCION-1:0] fila,
    output logic                      ocupado,
    output logic                      terminado
);

    typedef enum logic [2:0] {REPOSO, LEER, ESPERAR, CARGAR, LISTA, AVANZAR, FIN} estado_t;

    localparam logic [BITS_DIRECCION-1:0] PASO     = BITS_DIRECCION'(ANCHO_BLOQUES);
    localparam logic [BITS_DIRECCION-1:0] ULT_COL  = BITS_DIRECCION'(ANCHO_BLOQUES - 1);
    localparam logic [BITS_DIRECCION-1:0] ULT_FILA = BITS_DIRECCION'(ALTO_FILAS - 5);
    localparam logic [BITS_DIRECCION-1:0] UNO      = BITS_DIRECCION'(1);

    estado_t                   estado, siguiente;
    logic [2:0]                k;
    logic [BITS_DIRECCION-1:0] base;
    logic [BITS_DIRECCION-1:0] direccion;
    logic [63:0]               dato;
    logic                      hay_columna, hay_fila, ultima_fila;

    // base tracks fila*ANCHO_BLOQUES+columna; moving one block right or wrapping to the next row both add exactly 1
    assign hay_columna   = columna < ULT_COL;
    assign hay_fila      = fila < ULT_FILA;
    assign ultima_fila   = k == 3'd4;
    assign mem_direccion = direccion;
    assign datos_ventana = dato;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            estado <= REPOSO;
        else
            estado <= siguiente;
    end

    // next-state logic
    always_comb begin
        siguiente = estado;
        case (estado)
            REPOSO:  siguiente = iniciar ? LEER : REPOSO;
            LEER:    siguiente = ESPERAR;
            ESPERAR: siguiente = mem_valido ? CARGAR : ESPERAR;
            CARGAR:  siguiente = ultima_fila ? LISTA : LEER;
            LISTA:   siguiente = filtro_listo ? AVANZAR : LISTA;
            AVANZAR: siguiente = (hay_columna || hay_fila) ? LEER : FIN;
            FIN:     siguiente = REPOSO;
            default: siguiente = REPOSO;
        endcase
    end

    // window position, row counter, address stepping and captured word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            columna   <= '0;
            fila      <= '0;
            k         <= '0;
            base      <= '0;
            direccion <= '0;
            dato      <= '0;
        end else begin
            case (estado)
                REPOSO: if (iniciar) begin
                    columna   <= '0;
                    fila      <= '0;
                    k         <= '0;
                    base      <= '0;
                    direccion <= '0;
                end
                ESPERAR: if (mem_valido) dato <= mem_datos;
                CARGAR: begin
                    k <= ultima_fila ? 3'd0 : k + 3'd1;
                    if (!ultima_fila) direccion <= direccion + PASO;
                end
                AVANZAR: if (hay_columna || hay_fila) begin
                    columna   <= hay_columna ? columna + UNO : '0;
                    fila      <= hay_columna ? fila : fila + UNO;
                    base      <= base + UNO;
                    direccion <= base + UNO;
                end
                default: ;
            endcase
        end
    end

    // outputs decoded from the state
    always_comb begin
        mem_leer      = estado == LEER;
        guardar       = estado == CARGAR;
        ventana_lista = estado == LISTA;
        ocupado       = estado != REPOSO;
        terminado     = estado == FIN;
    end

    a_guardar_un_ciclo: assert property (@(posedge clk) disable iff (reset) guardar |=> !guardar);
    a_k_en_rango: assert property (@(posedge clk) disable iff (reset) k <= 3'd4);

endmodule
